alu_op_sequencer: RTL and testbench

Command-side initiator for the 4-bit ALU with register-file write-back. It accepts one operation per valid/ready transaction and drives the ALU operands, opcode, address and write-enable. It captures the result and flags, then reads the stored word back from the ALU register file and returns a response carrying result, flags and a readback-match bit. It sits between a test/host controller and the ALU, so the ALU is never driven directly by free-running stimulus.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_op_sequencer_if.sv | 55 +++++
 rtl/alu_seq_wait_cnt.sv | 30 +++
 rtl/alu_op_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned FLG_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;

  localparam int unsigned FLG_CARRY = 2;
  localparam int unsigned FLG_ZERO  = 1;
  localparam int unsigned FLG_NEG   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } seq_state_e;

  // Command payload as captured onto the ALU-side outputs.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] addr;
  } alu_cmd_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Host command/response and ALU-side signals of the sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned ERR_W = 8
);
  import alu_seq_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [DATA_W-1:0]    cmd_a;
  logic [DATA_W-1:0]    cmd_b;
  logic [OP_W-1:0]      cmd_opcode;
  logic [ADDR_W-1:0]    cmd_addr;

  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [OP_W-1:0]      alu_opcode;
  logic [ADDR_W-1:0]    alu_addr;
  logic                 alu_write_en;
  logic [DATA_W-1:0]    alu_result;
  logic [DATA_W-1:0]    alu_mem_out;
  logic                 alu_zero;
  logic                 alu_carry;
  logic                 alu_neg;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_result;
  logic [DATA_W-1:0]    rsp_readback;
  logic [FLG_W-1:0]     rsp_flags;
  logic                 rsp_match;
  logic [ERR_W-1:0]     mismatch_count;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_addr,
    input  alu_result, alu_mem_out, alu_zero, alu_carry, alu_neg,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode, alu_addr, alu_write_en,
    output rsp_valid, rsp_result, rsp_readback, rsp_flags, rsp_match,
    output mismatch_count
  );

  // Host plus ALU side.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_addr,
    output alu_result, alu_mem_out, alu_zero, alu_carry, alu_neg,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode, alu_addr, alu_write_en,
    input  rsp_valid, rsp_result, rsp_readback, rsp_flags, rsp_match,
    input  mismatch_count
  );

endinterface

// File: rtl/alu_seq_wait_cnt.sv
// Loadable down-counter used for the EXEC and READ latency waits.
module alu_seq_wait_cnt #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_c_o,
  output logic             near_c_o
);

  logic [CNT_W-1:0] count_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done_c_o = (count_q == '0);
  assign near_c_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation per command, writes it back, reads it back and
// returns result, flags and a readback-match bit.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave seq_bus
);

  localparam int unsigned MAX_LAT = (ALU_LAT > RD_LAT) ? ALU_LAT : RD_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [ERR_W-1:0] MCNT_MAX  = '1;

  seq_state_e          state_q;
  alu_cmd_t            cmd_q;
  logic                wr_en_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic [DATA_W-1:0]   rsp_readback_q;
  logic [FLG_W-1:0]    rsp_flags_q;
  logic                rsp_match_q;
  logic [ERR_W-1:0]    mcnt_q;

  logic                cnt_load_c;
  logic [CNT_W-1:0]    cnt_load_val_c;
  logic                cnt_dec_c;
  logic                cnt_done_c;
  logic                cnt_near_c;
  logic                match_c;

  alu_seq_wait_cnt #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_load_val_c),
    .dec_i      (cnt_dec_c),
    .done_c_o   (cnt_done_c),
    .near_c_o   (cnt_near_c)
  );

  // Wait counter is loaded on entry to EXEC and READ, decremented inside them.
  always_comb begin
    cnt_load_c     = 1'b0;
    cnt_load_val_c = '0;
    cnt_dec_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_bus.cmd_valid) begin
          cnt_load_c     = 1'b1;
          cnt_load_val_c = EXEC_LOAD;
        end
      end
      EXEC: begin
        if (cnt_done_c) begin
          cnt_load_c     = 1'b1;
          cnt_load_val_c = READ_LOAD;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end
      READ: begin
        cnt_dec_c = !cnt_done_c;
      end
      default: ;
    endcase
  end

  assign match_c = (seq_bus.alu_mem_out == rsp_result_q);

  // Sequencer FSM; the write strobe is pre-set so it is high only in the last EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      wr_en_q        <= 1'b0;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_readback_q <= '0;
      rsp_flags_q    <= '0;
      rsp_match_q    <= 1'b0;
      mcnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seq_bus.cmd_valid) begin
            cmd_q.a      <= seq_bus.cmd_a;
            cmd_q.b      <= seq_bus.cmd_b;
            cmd_q.opcode <= seq_bus.cmd_opcode;
            cmd_q.addr   <= seq_bus.cmd_addr;
            cmd_ready_q  <= 1'b0;
            wr_en_q      <= (ALU_LAT == 1);
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_done_c) begin
            rsp_result_q           <= seq_bus.alu_result;
            rsp_flags_q[FLG_CARRY] <= seq_bus.alu_carry;
            rsp_flags_q[FLG_ZERO]  <= seq_bus.alu_zero;
            rsp_flags_q[FLG_NEG]   <= seq_bus.alu_neg;
            wr_en_q                <= 1'b0;
            state_q                <= READ;
          end else if (cnt_near_c) begin
            wr_en_q <= 1'b1;
          end
        end
        READ: begin
          if (cnt_done_c) begin
            rsp_readback_q <= seq_bus.alu_mem_out;
            rsp_match_q    <= match_c;
            rsp_valid_q    <= 1'b1;
            state_q        <= RESP;
            if (!match_c && (mcnt_q != MCNT_MAX)) begin
              mcnt_q <= mcnt_q + ERR_W'(1);
            end
          end
        end
        RESP: begin
          if (seq_bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seq_bus.cmd_ready      = cmd_ready_q;
  assign seq_bus.alu_a          = cmd_q.a;
  assign seq_bus.alu_b          = cmd_q.b;
  assign seq_bus.alu_opcode     = cmd_q.opcode;
  assign seq_bus.alu_addr       = cmd_q.addr;
  assign seq_bus.alu_write_en   = wr_en_q;
  assign seq_bus.rsp_valid      = rsp_valid_q;
  assign seq_bus.rsp_result     = rsp_result_q;
  assign seq_bus.rsp_readback   = rsp_readback_q;
  assign seq_bus.rsp_flags      = rsp_flags_q;
  assign seq_bus.rsp_match      = rsp_match_q;
  assign seq_bus.mismatch_count = mcnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: instance 0 at default latencies, instance 1 at ALU_LAT=3, RD_LAT=2.
module tb_alu_op_sequencer;

  localparam int unsigned ERR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  int   exp_mcnt [2] = '{0, 0};

  typedef struct {
    int         inst;
    logic [3:0] result;
    logic [3:0] readback;
    logic [2:0] flags;
    logic       match;
    int         mcnt;
    int         acc_cyc;
    int         lat;
    int         alu_lat;
  } exp_t;

  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer_if #(.ERR_W(ERR_W)) u_if [2] ();

  alu_op_sequencer #(.ALU_LAT(1), .RD_LAT(1), .ERR_W(ERR_W)) u_dut0 (
    .clk (clk), .rst (rst), .seq_bus (u_if[0])
  );

  alu_op_sequencer #(.ALU_LAT(3), .RD_LAT(2), .ERR_W(ERR_W)) u_dut1 (
    .clk (clk), .rst (rst), .seq_bus (u_if[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errs++;
    $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
  endtask

  // Reference ALU: returns {carry, zero, neg, result}.
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] t;
    logic [3:0] r;
    logic       c;
    t = '0;
    c = 1'b0;
    case (op)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
      default: begin r = {1'b0, a[3:1]}; c = a[0]; end
    endcase
    return {c, (r == 4'd0), r[3], r};
  endfunction

  // ALU + register-file model with real latencies; outputs are inverted until valid.
  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int AL = (g == 0) ? 1 : 3;
    localparam int RL = (g == 0) ? 1 : 2;
    logic [3:0]  mem [16];
    logic [10:0] cur_in;
    logic [10:0] prev_in = '0;
    int          age = 0;
    int          rd_age = 0;
    logic [6:0]  fr;
    logic        ok;
    logic        rd_ok;
    logic [3:0]  rdv;
    int          wr_since = 0;
    int          wr_cyc = 0;
    bit          prev_v = 1'b0;
    exp_t        e;

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    assign cur_in = {u_if[g].alu_a, u_if[g].alu_b, u_if[g].alu_opcode};
    assign fr     = alu_fn(u_if[g].alu_a, u_if[g].alu_b, u_if[g].alu_opcode);
    assign ok     = (AL == 1) || ((cur_in == prev_in) && (age >= AL - 1));
    assign rd_ok  = (rd_age >= RL - 1);
    assign rdv    = mem[u_if[g].alu_addr] ^ (((g == 0) && (u_if[g].alu_addr == 4'd6)) ? 4'd1 : 4'd0);

    assign u_if[g].alu_result  = ok ? fr[3:0] : ~fr[3:0];
    assign u_if[g].alu_carry   = fr[6] ^ ~ok;
    assign u_if[g].alu_zero    = fr[5] ^ ~ok;
    assign u_if[g].alu_neg     = fr[4] ^ ~ok;
    assign u_if[g].alu_mem_out = rd_ok ? rdv : ~rdv;

    always @(posedge clk) begin
      age     <= (cur_in != prev_in) ? 1 : ((age < 64) ? age + 1 : age);
      prev_in <= cur_in;
      if (u_if[g].alu_write_en) begin
        mem[u_if[g].alu_addr] <= ok ? fr[3:0] : ~fr[3:0];
        rd_age <= 0;
      end else if (rd_age < 64) begin
        rd_age <= rd_age + 1;
      end
    end

    // Response monitor: pops the scoreboard on each response handshake.
    always @(negedge clk) begin
      if (rst) begin
        wr_since = 0;
        prev_v   = 1'b0;
      end else begin
        if (u_if[g].alu_write_en) begin
          wr_since++;
          wr_cyc = cyc;
        end
        if ((sbq.size() > 0) && (sbq[0].inst == g))
          chk($sformatf("cmd_ready_busy%0d", g), u_if[g].cmd_ready, 0);
        if (u_if[g].rsp_valid && !prev_v) begin
          if ((sbq.size() == 0) || (sbq[0].inst != g)) fail_now($sformatf("expected_rsp%0d", g));
          else chk($sformatf("latency%0d", g), cyc - sbq[0].acc_cyc, sbq[0].lat);
        end
        if (u_if[g].rsp_valid && u_if[g].rsp_ready && (sbq.size() > 0) && (sbq[0].inst == g)) begin
          e = sbq.pop_front();
          chk($sformatf("rsp_result%0d", g),   u_if[g].rsp_result,     e.result);
          chk($sformatf("rsp_readback%0d", g), u_if[g].rsp_readback,   e.readback);
          chk($sformatf("rsp_flags%0d", g),    u_if[g].rsp_flags,      e.flags);
          chk($sformatf("rsp_match%0d", g),    u_if[g].rsp_match,      e.match);
          chk($sformatf("mismatch_cnt%0d", g), u_if[g].mismatch_count, e.mcnt);
          chk($sformatf("write_pulses%0d", g), wr_since, 1);
          chk($sformatf("write_cycle%0d", g),  wr_cyc - e.acc_cyc, e.alu_lat);
          wr_since = 0;
        end
        prev_v = u_if[g].rsp_valid;
      end
    end
  end

  task automatic drive(input int inst, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] ad);
    if (inst == 0) begin
      u_if[0].cmd_valid = v; u_if[0].cmd_a = a; u_if[0].cmd_b = b;
      u_if[0].cmd_opcode = op; u_if[0].cmd_addr = ad;
    end else begin
      u_if[1].cmd_valid = v; u_if[1].cmd_a = a; u_if[1].cmd_b = b;
      u_if[1].cmd_opcode = op; u_if[1].cmd_addr = ad;
    end
  endtask

  function automatic logic rdy(input int inst);
    return (inst == 0) ? u_if[0].cmd_ready : u_if[1].cmd_ready;
  endfunction

  // Offer a command, wait for acceptance, push its hand-computed response.
  task automatic issue(input int inst, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [3:0] ad, input logic [3:0] er, input logic [2:0] ef, input bit push);
    exp_t e;
    bit   got;
    got = 1'b0;
    drive(inst, 1'b1, a, b, op, ad);
    for (int n = 0; (n < 100) && !got; n++) begin
      @(negedge clk);
      if (rdy(inst)) got = 1'b1;
    end
    if (!got) begin
      fail_now("cmd_accept");
      drive(inst, 1'b0, a, b, op, ad);
      return;
    end
    e.acc_cyc = cyc;
    @(posedge clk);
    if (push) begin
      e.inst     = inst;
      e.result   = er;
      e.flags    = ef;
      e.readback = ((inst == 0) && (ad == 4'd6)) ? (er ^ 4'd1) : er;
      e.match    = (e.readback == er);
      if (!e.match && (exp_mcnt[inst] < 255)) exp_mcnt[inst]++;
      e.mcnt     = exp_mcnt[inst];
      e.lat      = (inst == 0) ? 3 : 6;
      e.alu_lat  = (inst == 0) ? 1 : 3;
      sbq.push_back(e);
    end
    #1;
    drive(inst, 1'b0, a, b, op, ad);
  endtask

  task automatic drain();
    for (int n = 0; (n < 200) && (sbq.size() > 0); n++) @(negedge clk);
    if (sbq.size() > 0) begin
      fail_now("drain");
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] held;
    bit          seen;
    drive(0, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0);
    drive(1, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0);
    u_if[0].rsp_ready = 1'b1;
    u_if[1].rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", u_if[0].cmd_ready, 1);
    chk("rst_rsp_valid", u_if[0].rsp_valid, 0);
    chk("rst_write_en",  u_if[0].alu_write_en, 0);
    chk("rst_alu_a",     u_if[0].alu_a, 0);
    chk("rst_alu_addr",  u_if[0].alu_addr, 0);
    chk("rst_rsp_res",   u_if[0].rsp_result, 0);
    chk("rst_rsp_match", u_if[0].rsp_match, 0);
    chk("rst_mcnt",      u_if[0].mismatch_count, 0);
    chk("rst_cmd_ready1", u_if[1].cmd_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // Wrap-around add: 15+1 -> 0 with carry and zero.
    issue(0, 4'd15, 4'd1, 3'd0, 4'd3, 4'd0, 3'b110, 1);
    drain();

    // Back-to-back commands, last one reuses address 4.
    issue(0, 4'd10, 4'd3,  3'd0, 4'd4, 4'd13, 3'b001, 1);
    issue(0, 4'd11, 4'd7,  3'd1, 4'd5, 4'd4,  3'b000, 1);
    issue(0, 4'd12, 4'd10, 3'd2, 4'd7, 4'd8,  3'b001, 1);
    issue(0, 4'd1,  4'd1,  3'd0, 4'd4, 4'd2,  3'b000, 1);
    drain();

    // Corrupted readback at address 6.
    issue(0, 4'd2, 4'd3, 3'd0, 4'd6, 4'd5, 3'b000, 1);
    drain();

    // Response back-pressure for 5 cycles with a command already offered.
    u_if[0].rsp_ready = 1'b0;
    issue(0, 4'd6, 4'd9, 3'd3, 4'd12, 4'd15, 3'b001, 1);
    seen = 1'b0;
    for (int n = 0; (n < 20) && !seen; n++) begin
      @(negedge clk);
      if (u_if[0].rsp_valid) seen = 1'b1;
    end
    if (!seen) fail_now("stall_rsp_valid");
    held = {u_if[0].rsp_result, u_if[0].rsp_readback, u_if[0].rsp_flags};
    drive(0, 1'b1, 4'd0, 4'd0, 3'd7, 4'd13);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_rsp_hold",  {u_if[0].rsp_result, u_if[0].rsp_readback, u_if[0].rsp_flags}, held);
      chk("stall_rsp_valid", u_if[0].rsp_valid, 1);
      chk("stall_cmd_ready", u_if[0].cmd_ready, 0);
      chk("stall_write_en",  u_if[0].alu_write_en, 0);
    end
    @(posedge clk); #1 u_if[0].rsp_ready = 1'b1;
    issue(0, 4'd0, 4'd0, 3'd7, 4'd13, 4'd0, 3'b010, 1);
    drain();

    // Saturation of the mismatch counter.
    for (int n = 0; n < 300; n++) issue(0, 4'd2, 4'd3, 3'd0, 4'd6, 4'd5, 3'b000, 1);
    drain();
    @(negedge clk);
    chk("mcnt_saturated", u_if[0].mismatch_count, 255);
    @(posedge clk); #1;

    // Reset while the write strobe is high.
    issue(0, 4'd7, 4'd2, 3'd0, 4'd9, 4'd9, 3'b001, 0);
    chk("exec_write_en", u_if[0].alu_write_en, 1);
    #1 rst = 1'b1;
    #1 chk("async_write_drop", u_if[0].alu_write_en, 0);
    chk("rst_no_rsp", u_if[0].rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    exp_mcnt[0] = 0;
    @(negedge clk);
    chk("post_rst_ready", u_if[0].cmd_ready, 1);
    chk("post_rst_mcnt",  u_if[0].mismatch_count, 0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", u_if[0].rsp_valid, 0);
    end
    @(posedge clk); #1;
    issue(0, 4'd5, 4'd5, 3'd0, 4'd3, 4'd10, 3'b001, 1);
    drain();

    // Long-latency instance.
    issue(1, 4'd15, 4'd1, 3'd0, 4'd3,  4'd0,  3'b110, 1);
    issue(1, 4'd9,  4'd0, 3'd6, 4'd9,  4'd2,  3'b100, 1);
    issue(1, 4'd7,  4'd9, 3'd1, 4'd10, 4'd14, 3'b101, 1);
    issue(1, 4'd12, 4'd12, 3'd4, 4'd11, 4'd0, 3'b010, 1);
    issue(1, 4'd5,  4'd0, 3'd5, 4'd8,  4'd10, 3'b001, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
